exec_step_ctrl: RTL and testbench

- Run/halt/single-step execution controller for the RISC core on the board.
- Takes three raw push-buttons (run, step, halt) and filters each one with a shared sample-tick debounce scheme.
- Sequences the processor through a registered clock-enable.
- Sits between the board buttons and the core's clock-enable input. It replaces per-button divided clocks with a single-clock, tick-enabled design.

---
 rtl/exec_ctrl_pkg.sv | 23 ++
 rtl/exec_step_ctrl_btn_filter.sv | 55 +++++
 rtl/exec_step_ctrl.sv | 167 ++++++++++++++++
 tb/tb_exec_step_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_ctrl_pkg : shared state encoding and button indices for the     |
// |                 run/halt/step execution controller                   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package exec_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_HALT = 2;
  localparam int NUM_BTN  = 3;

endpackage
`default_nettype wire

// File: rtl/exec_step_ctrl_btn_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_filter : synchronizer, tick-sampled debounce and press pulse     |
// |              for one push-button                                     |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module btn_filter #(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic tick,
  output logic level,
  output logic press
);

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level_d;
  logic [CNT_W-1:0] r_stable_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      level        <= 1'b0;
      r_level_d    <= 1'b0;
      press        <= 1'b0;
      r_stable_cnt <= '0;
    end else begin
      r_sync1   <= btn;
      r_sync2   <= r_sync1;
      r_level_d <= level;
      press     <= level & ~r_level_d;
      if (tick) begin
        // The level flips on the STABLE_CNT-th consecutive differing sample.
        if (r_sync2 != level) begin
          if (r_stable_cnt == CNT_W'(STABLE_CNT - 1)) begin
            level        <= ~level;
            r_stable_cnt <= '0;
          end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
          end
        end else begin
          r_stable_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_step_ctrl : run/halt/single-step controller driving the core    |
// |                  clock enable. Option: EXEC_STEP_AUTO_REPEAT_EN      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module exec_step_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 200000,
  parameter int STABLE_CNT   = 4,
  parameter int BURST_W      = 8,
  parameter int REPEAT_TICKS = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_step,
  input  logic               btn_halt,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cpu_halted,
  output logic               cpu_ce,
  output logic [STATE_W-1:0] state,
  output logic               step_done
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic               w_step_pulse;
  logic               w_halt_p;
  logic               w_step_p;
  logic               w_run_p;
  state_t             r_state;
  logic               r_cpu_ce;
  logic               r_step_done;
  logic [BURST_W-1:0] r_burst;

  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_btn_raw[BTN_RUN]  = btn_run;
  assign w_btn_raw[BTN_STEP] = btn_step;
  assign w_btn_raw[BTN_HALT] = btn_halt;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_filter #(
      .STABLE_CNT (STABLE_CNT)
    ) u_filter (
      .clk   (clk),
      .reset (reset),
      .btn   (w_btn_raw[i]),
      .tick  (w_tick),
      .level (w_level[i]),
      .press (w_press[i])
    );
  end

`ifdef EXEC_STEP_AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_press;
  logic             unused_lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep_cnt   <= '0;
      r_rep_press <= 1'b0;
    end else begin
      r_rep_press <= 1'b0;
      if (!w_level[BTN_STEP]) begin
        r_rep_cnt <= '0;
      end else if (w_tick) begin
        if (r_rep_cnt == REP_W'(REPEAT_TICKS - 1)) begin
          r_rep_cnt   <= '0;
          r_rep_press <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end
    end
  end

  assign w_step_pulse = w_press[BTN_STEP] | r_rep_press;
  assign unused_lvl   = w_level[BTN_RUN] ^ w_level[BTN_HALT];
`else
  logic unused_cfg;

  assign w_step_pulse = w_press[BTN_STEP];
  assign unused_cfg   = (^w_level) ^ (REPEAT_TICKS == 0);
`endif

  // Same-cycle presses resolve halt > step > run.
  assign w_halt_p = w_press[BTN_HALT];
  assign w_step_p = w_step_pulse & ~w_halt_p;
  assign w_run_p  = w_press[BTN_RUN] & ~w_halt_p & ~w_step_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HALT;
      r_cpu_ce    <= 1'b0;
      r_step_done <= 1'b0;
      r_burst     <= '0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        ST_HALT: begin
          if (!cpu_halted) begin
            if (w_step_p) begin
              r_state  <= ST_STEP;
              r_cpu_ce <= 1'b1;
              r_burst  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            end else if (w_run_p) begin
              r_state  <= ST_RUN;
              r_cpu_ce <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_halt_p || cpu_halted) begin
            r_state  <= ST_HALT;
            r_cpu_ce <= 1'b0;
          end
        end
        ST_STEP: begin
          if (w_halt_p) begin
            r_state  <= ST_HALT;
            r_cpu_ce <= 1'b0;
            r_burst  <= '0;
          end else if (cpu_halted || (r_burst == BURST_W'(1))) begin
            r_state     <= ST_HALT;
            r_cpu_ce    <= 1'b0;
            r_step_done <= 1'b1;
            r_burst     <= '0;
          end else begin
            r_burst <= r_burst - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_HALT;
          r_cpu_ce <= 1'b0;
          r_burst  <= '0;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign cpu_ce    = r_cpu_ce;
  assign step_done = r_step_done;

endmodule
`default_nettype wire

// File: tb/tb_exec_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_step_ctrl : scoreboard bench for exec_step_ctrl              |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_exec_step_ctrl;

  localparam int S_HALT = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       btn_run    = 1'b0;
  logic       btn_step   = 1'b0;
  logic       btn_halt   = 1'b0;
  logic       cpu_halted = 1'b0;
  logic [7:0] burst_len  = 8'd0;
  logic       cpu_ce;
  logic       step_done;
  logic [1:0] state;

  always #5 clk = ~clk;

  exec_step_ctrl #(
    .TICK_DIV     (4),
    .STABLE_CNT   (3),
    .BURST_W      (8),
    .REPEAT_TICKS (250)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .btn_halt   (btn_halt),
    .burst_len  (burst_len),
    .cpu_halted (cpu_halted),
    .cpu_ce     (cpu_ce),
    .state      (state),
    .step_done  (step_done)
  );

  int errors = 0;
  int checks = 0;

  // One entry per expected enable window; len 0 means length not predicted.
  typedef struct {
    int   len;
    bit   done;
    int   st;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  bit   in_win = 1'b0;
  int   win_len = 0;
  int   win_st = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int len, input bit done, input int st);
    exp_t e;
    e.len  = len;
    e.done = done;
    e.st   = st;
    return e;
  endfunction

  // Monitor: closes a window when cpu_ce falls and scores it.
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      if (!in_win) begin
        in_win  = 1'b1;
        win_len = 0;
        win_st  = int'(state);
      end
      win_len++;
    end else if (in_win) begin
      in_win = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_window", 1, 0);
      end else begin
        cur_exp = exp_q.pop_front();
        if (cur_exp.len != 0) check("window_len", win_len, cur_exp.len);
        check("window_step_done", int'(step_done), int'(cur_exp.done));
        check("window_state", win_st, cur_exp.st);
      end
    end else if (step_done === 1'b1) begin
      check("spurious_step_done", 1, 0);
    end
  end

  task automatic drive(input logic [2:0] mask, input logic v);
    btn_run  = mask[0] & v;
    btn_step = mask[1] & v;
    btn_halt = mask[2] & v;
  endtask

  // Bouncy press: bounce segments never span 3 sample ticks, then a solid hold.
  task automatic press(input logic [2:0] mask, input int nseg, input bit fixed_seg,
                       input bit scramble);
    logic lvl;
    int   len;
    int   nrel;
    @(negedge clk);
    lvl = 1'b1;
    for (int s = 0; s < nseg; s++) begin
      len = fixed_seg ? 8 : int'($urandom_range(1, 8));
      drive(mask, lvl);
      repeat (len) @(negedge clk);
      lvl = ~lvl;
    end
    drive(mask, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (scramble && cpu_ce === 1'b1) burst_len = 8'($urandom);
    end
    lvl  = 1'b0;
    nrel = int'($urandom_range(0, 5));
    for (int s = 0; s < nrel; s++) begin
      len = int'($urandom_range(1, 8));
      drive(mask, lvl);
      repeat (len) @(negedge clk);
      lvl = ~lvl;
    end
    drive(mask, 1'b0);
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_ce();
    int n;
    n = 0;
    @(negedge clk);
    while (cpu_ce !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (cpu_ce !== 1'b1) check("wait_ce_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (5) @(negedge clk);
    check("reset_state", int'(state), S_HALT);
    check("reset_cpu_ce", int'(cpu_ce), 0);
    check("reset_step_done", int'(step_done), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Run button bouncing every 2 ticks for 12 ticks
    exp_q.push_back(mk(0, 1'b0, S_RUN));
    press(3'b001, 6, 1'b1, 1'b0);
    check("run_state", int'(state), S_RUN);
    check("run_cpu_ce", int'(cpu_ce), 1);
    // Halt and run debounced together in RUN
    press(3'b101, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    check("halt_run_state", int'(state), S_HALT);
    check("halt_run_cpu_ce", int'(cpu_ce), 0);

    // Step bursts
    burst_len = 8'd5;
    exp_q.push_back(mk(5, 1'b1, S_STEP));
    press(3'b010, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    check("step5_state", int'(state), S_HALT);
    burst_len = 8'd0;
    exp_q.push_back(mk(1, 1'b1, S_STEP));
    press(3'b010, int'($urandom_range(0, 6)), 1'b0, 1'b0);

    // Priority in HALT
    press(3'b110, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    check("halt_over_step_state", int'(state), S_HALT);
    press(3'b101, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    check("halt_over_run_state", int'(state), S_HALT);
    burst_len = 8'd3;
    exp_q.push_back(mk(3, 1'b1, S_STEP));
    press(3'b011, int'($urandom_range(0, 6)), 1'b0, 1'b0);

    // Randomized sessions
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        n = int'($urandom_range(0, 15));
        burst_len = 8'(n);
        exp_q.push_back(mk((n == 0) ? 1 : n, 1'b1, S_STEP));
        press(3'b010, int'($urandom_range(0, 6)), 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        exp_q.push_back(mk(0, 1'b0, S_RUN));
        press(3'b001, int'($urandom_range(0, 6)), 1'b0, 1'b0);
        if ($urandom_range(0, 1) != 0)
          press(3'b010, int'($urandom_range(0, 6)), 1'b0, 1'b0);
        check("rand_run_state", int'(state), S_RUN);
        press(3'b100, int'($urandom_range(0, 6)), 1'b0, 1'b0);
        check("rand_halt_state", int'(state), S_HALT);
      end
    end

    // cpu_halted during RUN, then presses ignored while it stays high
    n = int'($urandom_range(2, 9));
    exp_q.push_back(mk(n, 1'b0, S_RUN));
    @(negedge clk);
    btn_run = 1'b1;
    wait_ce();
    repeat (n - 1) @(negedge clk);
    cpu_halted = 1'b1;
    btn_run = 1'b0;
    repeat (40) @(negedge clk);
    press(3'b001, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    press(3'b010, int'($urandom_range(0, 6)), 1'b0, 1'b0);
    check("halted_lock_state", int'(state), S_HALT);
    check("halted_lock_cpu_ce", int'(cpu_ce), 0);
    cpu_halted = 1'b0;

    // cpu_halted during STEP ends the burst with step_done
    burst_len = 8'd20;
    exp_q.push_back(mk(7, 1'b1, S_STEP));
    @(negedge clk);
    btn_step = 1'b1;
    wait_ce();
    repeat (6) @(negedge clk);
    cpu_halted = 1'b1;
    btn_step = 1'b0;
    repeat (40) @(negedge clk);
    cpu_halted = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-burst (counter at 3)
    burst_len = 8'd6;
    exp_q.push_back(mk(4, 1'b0, S_STEP));
    @(negedge clk);
    btn_step = 1'b1;
    wait_ce();
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    btn_step = 1'b0;
    #1;
    check("async_reset_cpu_ce", int'(cpu_ce), 0);
    check("async_reset_state", int'(state), S_HALT);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_state", int'(state), S_HALT);
    check("post_reset_cpu_ce", int'(cpu_ce), 0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
